// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - gshare pattern history table with self-initialisation and global history
module gshare_pht #(
    parameter int R    = 6,
    parameter int M    = 2,
    parameter int CW   = 2,
    parameter int HASH = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_valid,
    input  logic [R+M-1:0]   pred_pc,
    output logic             pred_ready,
    output logic             resp_valid,
    output logic             resp_taken,
    output logic [R+M-1:0]   resp_idx,
    input  logic             upd_valid,
    input  logic [R+M-1:0]   upd_idx,
    input  logic             upd_taken,
    output logic [M-1:0]     ghr
);

    localparam int IW    = R + M;
    localparam int DEPTH = 1 << IW;
    localparam logic [CW-1:0] WEAK_NT = CW'((1 << (CW - 1)) - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   init_idx;
    logic [CW-1:0]   cnt [DEPTH];

    logic            pred_fire;
    logic            upd_fire;
    logic [IW-1:0]   pred_idx;
    logic [IW-1:0]   idx_cat;
    logic [IW-1:0]   idx_hash;
    logic [CW-1:0]   upd_cur;
    logic [CW-1:0]   upd_new;
    logic [CW-1:0]   pred_cnt;
    logic [M-1:0]    ghr_shift;

    assign pred_ready = (state == S_RUN);
    assign pred_fire  = pred_valid && pred_ready;
    assign upd_fire   = upd_valid && (state == S_RUN);

    // Prediction index always uses the current (pre-update) history.
    assign idx_cat  = {ghr, pred_pc[R-1:0]};
    assign idx_hash = {pred_pc[IW-1:R] ^ ghr, pred_pc[R-1:0]};
    assign pred_idx = (HASH != 0) ? idx_hash : idx_cat;

    generate
        if (M == 1) begin : g_ghr1
            assign ghr_shift = upd_taken;
        end else begin : g_ghrn
            assign ghr_shift = {ghr[M-2:0], upd_taken};
        end
    endgenerate

    always_comb begin
        upd_cur = cnt[upd_idx];
        upd_new = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CNT_MAX) upd_new = upd_cur + CW'(1);
        end else begin
            if (upd_cur != '0) upd_new = upd_cur - CW'(1);
        end
    end

    // Write-first bypass when the same entry is updated on the predict edge.
    always_comb begin
        pred_cnt = cnt[pred_idx];
        if (upd_fire && (upd_idx == pred_idx)) pred_cnt = upd_new;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_idx == IW'(DEPTH - 1)) state_nxt = S_RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_INIT;
            init_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) init_idx <= init_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            cnt[init_idx] <= WEAK_NT;
        end else if (upd_fire) begin
            cnt[upd_idx] <= upd_new;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            resp_idx   <= '0;
            ghr        <= '0;
        end else begin
            resp_valid <= pred_fire;
            if (pred_fire) begin
                resp_taken <= pred_cnt[CW-1];
                resp_idx   <= pred_idx;
            end
            if (upd_fire) ghr <= ghr_shift;
        end
    end

endmodule
